// File: rtl/max_bus_sched.sv
// Cycle scheduler for the MAX shared bus: phi half-cycles, VIC/CPU enable strobes and the BA/AEC steal handshake.
// Optional steal watchdog enabled by defining MAX_BUS_WATCHDOG_EN.
module max_bus_sched #(
  parameter int HALF      = 4,
  parameter int BA_LEAD   = 3,
  parameter int MAX_STEAL = 43
) (
  input  logic clk_cpu,
  input  logic reset,
  input  logic vic_req,
  output logic phi,
  output logic vic_en,
  output logic cpu_en,
  output logic ba,
  output logic aec,
  output logic ram_sel,
  output logic steal_err
);

  localparam int HC_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF - 1);
  localparam logic [2:0] LEAD_LAST = 3'(BA_LEAD - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BA_WAIT = 2'd1,
    VIC_OWN = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [HC_W-1:0] hc;
  logic [2:0]      lead, lead_nxt;
  logic            hc_last;

`ifdef MAX_BUS_WATCHDOG_EN
  localparam int ST_W = $clog2(MAX_STEAL + 1);
  localparam logic [ST_W-1:0] STEAL_LAST = ST_W'(MAX_STEAL - 1);
  logic [ST_W-1:0] steal, steal_nxt;
  logic            err_q, err_nxt;
`endif

  // Strobes and bus selects decode registered state only, so they are glitch-free per clock.
  assign hc_last = (hc == HC_LAST);
  assign vic_en  = ~phi & hc_last;
  assign cpu_en  = phi & hc_last & aec;
  assign ba      = (state == IDLE);
  assign aec     = (state != VIC_OWN);
  assign ram_sel = ~phi | ~aec;

  always_ff @(posedge clk_cpu) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      hc  <= '0;
      phi <= 1'b0;
    end else if (hc_last) begin
      hc  <= '0;
      phi <= ~phi;
    end else begin
      hc  <= hc + HC_W'(1);
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    lead_nxt  = lead;
`ifdef MAX_BUS_WATCHDOG_EN
    steal_nxt = steal;
    err_nxt   = err_q;
`endif
    unique case (state)
      IDLE: begin
        if (vic_en && vic_req) begin
          state_nxt = BA_WAIT;
          lead_nxt  = '0;
        end
      end
      BA_WAIT: begin
        if (vic_en && !vic_req) begin
          state_nxt = IDLE;
          lead_nxt  = '0;
        end else if (cpu_en) begin
          if (lead == LEAD_LAST) begin
            state_nxt = VIC_OWN;
            lead_nxt  = '0;
          end else begin
            lead_nxt  = lead + 3'd1;
          end
        end
      end
      VIC_OWN: begin
        if (vic_en) begin
          if (!vic_req) begin
            state_nxt = IDLE;
          end
`ifdef MAX_BUS_WATCHDOG_EN
          // Forced release hands the CPU at least one full cycle before BA can fall again.
          else if (steal == STEAL_LAST) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end else begin
            steal_nxt = steal + ST_W'(1);
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef MAX_BUS_WATCHDOG_EN
    if (state_nxt == IDLE) steal_nxt = '0;
`endif
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state <= IDLE;
      lead  <= '0;
    end else begin
      state <= state_nxt;
      lead  <= lead_nxt;
    end
  end

`ifdef MAX_BUS_WATCHDOG_EN
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      steal <= '0;
      err_q <= 1'b0;
    end else begin
      steal <= steal_nxt;
      err_q <= err_nxt;
    end
  end

  assign steal_err = err_q;
`else
  assign steal_err = 1'b0;
`endif

endmodule

// File: tb/tb_max_bus_sched.sv
// Directed, table-driven bench for max_bus_sched (HALF=4, BA_LEAD=3, MAX_STEAL=5).
module tb_max_bus_sched;

  localparam int HALF      = 4;
  localparam int BA_LEAD   = 3;
  localparam int MAX_STEAL = 5;

  logic clk_cpu = 1'b0;
  logic reset   = 1'b1;
  logic vic_req = 1'b0;
  logic phi, vic_en, cpu_en, ba, aec, ram_sel, steal_err;

  int checks = 0;
  int errors = 0;
  int kk     = 0;

  // exp = {phi, vic_en, cpu_en, ba, aec, ram_sel, steal_err}
  typedef struct {
    logic       rst;
    logic       req;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[$];

  max_bus_sched #(
    .HALF      (HALF),
    .BA_LEAD   (BA_LEAD),
    .MAX_STEAL (MAX_STEAL)
  ) dut (
    .clk_cpu   (clk_cpu),
    .reset     (reset),
    .vic_req   (vic_req),
    .phi       (phi),
    .vic_en    (vic_en),
    .cpu_en    (cpu_en),
    .ba        (ba),
    .aec       (aec),
    .ram_sel   (ram_sel),
    .steal_err (steal_err)
  );

  always #5 clk_cpu = ~clk_cpu;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Row for the clock kk cycles after the last reset edge; strobe timing follows HALF=4.
  task automatic push(input logic rst, input logic req, input logic b, input logic a, input logic e);
    vec_t v;
    logic p;
    p     = ((kk / 4) % 2) == 1;
    v.rst = rst;
    v.req = req;
    v.exp = {p, (kk % 8) == 3, ((kk % 8) == 7) && a, b, a, !p || !a, e};
    tbl.push_back(v);
    kk = rst ? 0 : kk + 1;
  endtask

  initial begin
    int t_ba, t_aec, cpu_after;

    // Idle after reset: strobes only, bus stays with the CPU.
    for (int k = 0; k < 20; k++) push(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    // vic_req held: BA falls at 4, three CPU cycles, AEC falls at 24.
    for (int k = 0; k < 32; k++) push(1'b0, 1'b1, kk < 4, kk < 24, 1'b0);
    // Release from VIC_OWN at vic_en 35: BA and AEC rise together.
    for (int k = 0; k < 12; k++) push(1'b0, 1'b0, kk >= 36, kk >= 36, 1'b0);
    // Request only between vic_en strobes is ignored.
    for (int k = 0; k < 16; k++) push(1'b0, (kk % 8) != 3, 1'b1, 1'b1, 1'b0);
    // Request withdrawn in BA_WAIT after one cpu_en.
    for (int k = 0; k < 24; k++)
      push(1'b0, kk >= 67 && kk <= 74, !(kk >= 68 && kk <= 75), 1'b1, 1'b0);
    // Reach VIC_OWN again, then reset one clock after AEC falls.
    for (int k = 0; k < 29; k++) push(1'b0, 1'b1, kk < 92, kk < 112, 1'b0);
    push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) push(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    push(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    // Long steal: bounded by the watchdog when enabled, unbounded otherwise.
    for (int k = 0; k < 96; k++) begin
`ifdef MAX_BUS_WATCHDOG_EN
      push(1'b0, 1'b1, kk < 4 || (kk >= 60 && kk < 68), kk < 24 || (kk >= 60 && kk < 88), kk >= 60);
`else
      push(1'b0, 1'b1, kk < 4, kk < 24, 1'b0);
`endif
    end
`ifdef MAX_BUS_WATCHDOG_EN
    push(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
`else
    push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
    for (int k = 0; k < 4; k++) push(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    reset   = 1'b1;
    vic_req = 1'b0;
    @(negedge clk_cpu);
    @(negedge clk_cpu);
    for (int i = 0; i < tbl.size(); i++) begin
      reset   = tbl[i].rst;
      vic_req = tbl[i].req;
      check($sformatf("row%0d", i), {25'd0, phi, vic_en, cpu_en, ba, aec, ram_sel, steal_err},
            {25'd0, tbl[i].exp});
      @(negedge clk_cpu);
    end

    // Hand-measured handshake: BA-fall to AEC-fall and CPU silence while AEC is low.
    reset = 1'b1;
    @(negedge clk_cpu);
    reset     = 1'b0;
    vic_req   = 1'b1;
    t_ba      = -1;
    t_aec     = -1;
    cpu_after = 0;
    for (int c = 0; c < 60; c++) begin
      if (ba === 1'b0 && t_ba < 0) t_ba = c;
      if (aec === 1'b0 && t_aec < 0) t_aec = c;
      if (t_aec >= 0 && aec === 1'b0 && cpu_en === 1'b1) cpu_after++;
      @(negedge clk_cpu);
    end
    check("ba_fall_clock", t_ba, 32'd4);
    check("aec_fall_clock", t_aec, 32'd24);
    check("ba_to_aec", t_aec - t_ba, BA_LEAD * 2 * HALF - HALF);
    check("cpu_en_while_aec_low", cpu_after, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
